// File: rtl/fa_check_pkg.sv
// Shared types for the full-adder response checker: FSM states, applied vector, golden result.
// Pure definitions; no latency or flow control of its own.
package fa_check_pkg;

    localparam int MAX_DUT_LAT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_t;

    typedef struct packed {
        logic a;
        logic b;
        logic c;
    } fa_vec_t;

    typedef struct packed {
        logic sum;
        logic cout;
    } fa_res_t;

    // Expected result travels with the vector so a mismatch can report what was applied.
    typedef struct packed {
        fa_res_t golden;
        fa_vec_t vec;
    } exp_rec_t;

    function automatic fa_res_t fa_golden(fa_vec_t v);
        fa_res_t r;
        r.sum  = v.a ^ v.b ^ v.c;
        r.cout = (v.a & v.b) | (v.a & v.c) | (v.b & v.c);
        return r;
    endfunction

endpackage

// File: rtl/fa_resp_checker_if.sv
// Stimulus, DUT-result and status bundle of the full-adder response checker; cov_mask only with FA_CHECK_COVERAGE_EN.
// Wires only: no latency, no backpressure (vectors are fire-and-forget).
interface fa_resp_checker_if #(
    parameter int ERR_W = 4
);
    logic             start;
    logic             vec_valid;
    logic             a;
    logic             b;
    logic             c;
    logic             sum;
    logic             cout;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [7:0]       vec_count;
    logic [2:0]       first_err_vec;
    logic             first_err_valid;
`ifdef FA_CHECK_COVERAGE_EN
    logic [7:0]       cov_mask;

    modport master (
        output start, vec_valid, a, b, c, sum, cout,
        input  busy, done, pass, err_count, vec_count, first_err_vec, first_err_valid, cov_mask
    );
    modport slave (
        input  start, vec_valid, a, b, c, sum, cout,
        output busy, done, pass, err_count, vec_count, first_err_vec, first_err_valid, cov_mask
    );
`else
    modport master (
        output start, vec_valid, a, b, c, sum, cout,
        input  busy, done, pass, err_count, vec_count, first_err_vec, first_err_valid
    );
    modport slave (
        input  start, vec_valid, a, b, c, sum, cout,
        output busy, done, pass, err_count, vec_count, first_err_vec, first_err_valid
    );
`endif
endinterface

// File: rtl/fa_exp_delay.sv
// Shift register aligning expected records with DUT outputs; latency DUT_LAT cycles (>=1).
// No backpressure; synchronous flush drops every in-flight valid.
module fa_exp_delay
    import fa_check_pkg::*;
#(
    parameter int DUT_LAT = 1
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     flush,
    input  logic     in_vld,
    input  exp_rec_t in_dat,
    output logic     out_vld,
    output exp_rec_t out_dat
);

    logic     [DUT_LAT-1:0] vld_q, vld_d;
    exp_rec_t [DUT_LAT-1:0] dat_q, dat_d;

    always_comb begin
        vld_d    = vld_q;
        dat_d    = dat_q;
        vld_d[0] = in_vld;
        dat_d[0] = in_dat;
        for (int i = 1; i < DUT_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
        if (flush) begin
            vld_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign out_vld = vld_q[DUT_LAT-1];
    assign out_dat = dat_q[DUT_LAT-1];

endmodule

// File: rtl/fa_resp_checker.sv
// Golden-compares full-adder DUT outputs, counts mismatches, reports done/pass; FA_CHECK_COVERAGE_EN adds cov_mask.
// Compare DUT_LAT cycles after vec_valid, registered on the next edge; no backpressure, vectors outside RUN are dropped.
module fa_resp_checker
    import fa_check_pkg::*;
#(
    parameter int NUM_VECTORS = 8,
    parameter int DUT_LAT     = 0,
    parameter int ERR_W       = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    fa_resp_checker_if.slave chk
);

    localparam int         LAT      = (DUT_LAT > MAX_DUT_LAT) ? MAX_DUT_LAT : DUT_LAT;
    localparam logic [7:0] NUM_VEC8 = 8'(NUM_VECTORS);

    chk_state_t       state_q, state_d;
    logic [7:0]       vec_count_q, vec_count_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    fa_vec_t          first_err_vec_q, first_err_vec_d;
    logic             first_err_valid_q, first_err_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             all_seen;
`ifdef FA_CHECK_COVERAGE_EN
    logic [7:0]       cov_q, cov_d;
`endif

    fa_vec_t  in_vec;
    exp_rec_t in_rec;
    exp_rec_t dly_rec;
    logic     acc_vld;
    logic     dly_vld;
    logic     mismatch;

    always_comb begin
        in_vec.a      = chk.a;
        in_vec.b      = chk.b;
        in_vec.c      = chk.c;
        in_rec.golden = fa_golden(in_vec);
        in_rec.vec    = in_vec;
    end

    // The start cycle never feeds the delay line: that vector belongs to no run.
    assign acc_vld  = chk.vec_valid && (state_q == RUN) && !chk.start;
    assign mismatch = (chk.sum != dly_rec.golden.sum) || (chk.cout != dly_rec.golden.cout);

    generate
        if (LAT == 0) begin : g_no_delay
            assign dly_vld = acc_vld;
            assign dly_rec = in_rec;
        end else begin : g_delay
            fa_exp_delay #(
                .DUT_LAT (LAT)
            ) u_exp_delay (
                .clk     (clk),
                .reset_n (reset_n),
                .flush   (chk.start),
                .in_vld  (acc_vld),
                .in_dat  (in_rec),
                .out_vld (dly_vld),
                .out_dat (dly_rec)
            );
        end
    endgenerate

    always_comb begin
        state_d           = state_q;
        vec_count_d       = vec_count_q;
        err_count_d       = err_count_q;
        first_err_vec_d   = first_err_vec_q;
        first_err_valid_d = first_err_valid_q;
`ifdef FA_CHECK_COVERAGE_EN
        cov_d             = cov_q;
`endif
        case (state_q)
            IDLE: ;
            RUN: begin
                if (dly_vld) begin
                    vec_count_d = vec_count_q + 8'd1;
`ifdef FA_CHECK_COVERAGE_EN
                    cov_d[dly_rec.vec] = 1'b1;
`endif
                    if (mismatch) begin
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + ERR_W'(1);
                        end
                        if (!first_err_valid_q) begin
                            first_err_vec_d   = dly_rec.vec;
                            first_err_valid_d = 1'b1;
                        end
                    end
                    if (vec_count_d == NUM_VEC8) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: ;
            default: state_d = IDLE;
        endcase
        if (chk.start) begin
            state_d           = RUN;
            vec_count_d       = '0;
            err_count_d       = '0;
            first_err_vec_d   = '0;
            first_err_valid_d = 1'b0;
`ifdef FA_CHECK_COVERAGE_EN
            cov_d             = '0;
`endif
        end
`ifdef FA_CHECK_COVERAGE_EN
        all_seen = (cov_d == 8'hFF);
`else
        all_seen = 1'b1;
`endif
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
        pass_d = done_d && (err_count_d == '0) && all_seen;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= IDLE;
            vec_count_q       <= '0;
            err_count_q       <= '0;
            first_err_vec_q   <= '0;
            first_err_valid_q <= 1'b0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            pass_q            <= 1'b0;
`ifdef FA_CHECK_COVERAGE_EN
            cov_q             <= '0;
`endif
        end else begin
            state_q           <= state_d;
            vec_count_q       <= vec_count_d;
            err_count_q       <= err_count_d;
            first_err_vec_q   <= first_err_vec_d;
            first_err_valid_q <= first_err_valid_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
            pass_q            <= pass_d;
`ifdef FA_CHECK_COVERAGE_EN
            cov_q             <= cov_d;
`endif
        end
    end

    assign chk.busy            = busy_q;
    assign chk.done            = done_q;
    assign chk.pass            = pass_q;
    assign chk.err_count       = err_count_q;
    assign chk.vec_count       = vec_count_q;
    assign chk.first_err_vec   = first_err_vec_q;
    assign chk.first_err_valid = first_err_valid_q;
`ifdef FA_CHECK_COVERAGE_EN
    assign chk.cov_mask        = cov_q;
`endif

endmodule
